// File: rtl/switch_debouncer_pkg.sv
// Shared constants, channel state type and helpers
// for the Basys3 switch/button debouncer.
package switch_debouncer_pkg;

  localparam int CLK_HZ        = 100_000_000;
  localparam int DEBOUNCE_10MS = 1_000_000;
  localparam int DEBOUNCE_SIM  = 4;

  localparam int STABLE_MIN = 2;
  localparam int STABLE_MAX = 2 ** 24;

  // A channel is either holding its level or counting
  // consecutive mismatching samples; the counter encodes it.
  typedef enum logic {
    CH_STABLE   = 1'b0,
    CH_SETTLING = 1'b1
  } ch_state_e;

  // Counter width; clamped so an illegal setting still
  // elaborates far enough to report the range error.
  function automatic int cnt_width(input int n);
    return (n < STABLE_MIN) ? 1 : $clog2(n);
  endfunction

  function automatic ch_state_e ch_state_of(input logic settling);
    return settling ? CH_SETTLING : CH_STABLE;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debouncer: 2-flop synchroniser, settle
// counter, registered level and one-cycle edge strobes.
module debounce_channel
  import switch_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_10MS,
  parameter int CNT_W         = cnt_width(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  ch_state_e        state;

  assign state = ch_state_of(cnt_q != '0);

  // Next-state: sync pipeline, settle counting, accept/reject.
  always_comb begin
    s1_d   = raw;
    s2_d   = s1_q;
    cnt_d  = cnt_q;
    q_d    = q_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    unique case (state)
      CH_STABLE: begin
        if (s2_q != q_q) cnt_d = CNT_ONE;
      end
      CH_SETTLING: begin
        if (s2_q == q_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          q_d    = s2_q;
          cnt_d  = '0;
          rise_d = s2_q;
          fall_d = ~s2_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  // State registers; async reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      q_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH raw switch/button inputs; each channel
// is an independent debounce_channel.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = DEBOUNCE_10MS
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RAW,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);

  if (STABLE_CYCLES < STABLE_MIN || STABLE_CYCLES > STABLE_MAX)
  begin : g_bad_stable
    $error("switch_debouncer: STABLE_CYCLES %0d out of range",
           STABLE_CYCLES);
  end

  if (WIDTH < 1) begin : g_bad_width
    $error("switch_debouncer: WIDTH must be at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk (CLK),
      .rst (RST),
      .raw (RAW[i]),
      .q   (Q[i]),
      .rise(RISE[i]),
      .fall(FALL[i])
    );
  end

endmodule
